// File: rtl/lock_pkg.sv
// Shared types for the combination-lock sequencer and its display mux.
// The state encoding doubles as msg_mode so the seven-seg mux decodes it directly.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        PASS   = 2'd1,
        FAIL   = 2'd2,
        LOCKED = 2'd3
    } lock_state_e;

    // Seven-seg glyph codes beyond the decimal digits.
    localparam logic [3:0] GLYPH_P     = 4'd10;
    localparam logic [3:0] GLYPH_A     = 4'd11;
    localparam logic [3:0] GLYPH_F     = 4'd12;
    localparam logic [3:0] GLYPH_L     = 4'd13;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    // Message selector presented to the display mux for a given state.
    function automatic logic [1:0] msg_mode_of(lock_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/lock_attempt_ctrl_if.sv
// Key/comparator/display bundle between the lock sequencer and the board side.
// master: board keys and comparator driving the sequencer; slave: the sequencer.
interface lock_attempt_ctrl_if #(
    parameter int unsigned FAIL_W = 2
) ();

    logic              key_enter;
    logic              match;
    logic              entry_en;
    logic [1:0]        msg_mode;
    logic              scroll_tick;
    logic [FAIL_W-1:0] fail_cnt;
    logic              lockout;

    modport master (
        output key_enter,
        output match,
        input  entry_en,
        input  msg_mode,
        input  scroll_tick,
        input  fail_cnt,
        input  lockout
    );

    modport slave (
        input  key_enter,
        input  match,
        output entry_en,
        output msg_mode,
        output scroll_tick,
        output fail_cnt,
        output lockout
    );

endinterface

// File: rtl/lock_key_pulse.sv
// Debounces a raw active-low key into a single registered one-cycle pulse.
// The low-level counter saturates one past the threshold so a held key
// never repeats; any high sample restarts it.
module lock_key_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic pulse_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CntW-1:0] CntHit = CntW'(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntSat = CntW'(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    // Count low samples, hold at saturation, pulse once on reaching the threshold.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = (cnt_q == CntHit);
        if (key_ni) begin
            cnt_d = '0;
        end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Debounce state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/lock_attempt_ctrl.sv
// Combination-lock attempt sequencer: debounced ENTER, pass/fail decision,
// consecutive-failure count, timed lockout and message scroll tick.
// Build option: define LOCK_ATTEMPT_SCROLL_EN to get the scroll counter and
// scroll_tick; otherwise scroll_tick is tied low (static message display).
module lock_attempt_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCROLL_CYCLES   = 1000000,
    parameter int unsigned LOCK_CYCLES     = 500000000,
    parameter int unsigned MAX_FAIL        = 3,
    parameter int unsigned FAIL_W          = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    lock_attempt_ctrl_if.slave  ctrl_io
);

    localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LockW-1:0]  LockLast = LockW'(LOCK_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FailMax  = FAIL_W'(MAX_FAIL);

    logic              enter_pulse;
    lock_state_e       state_q, state_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [LockW-1:0]  lock_q, lock_d;
    logic              entry_en_q;
    logic [1:0]        msg_q;
    logic              lockout_q;

    lock_key_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_key (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .key_ni (ctrl_io.key_enter),
        .pulse_o(enter_pulse)
    );

    // Next-state logic: match only matters on the ENTER pulse; LOCKED ignores ENTER.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        lock_d  = '0;
        unique case (state_q)
            ENTRY: begin
                if (enter_pulse) begin
                    if (ctrl_io.match) begin
                        state_d = PASS;
                        fail_d  = '0;
                    end else begin
                        fail_d  = (fail_q == FailMax) ? FailMax : fail_q + FAIL_W'(1);
                        state_d = (fail_d == FailMax) ? LOCKED : FAIL;
                    end
                end
            end
            PASS, FAIL: begin
                if (enter_pulse) begin
                    state_d = ENTRY;
                end
            end
            LOCKED: begin
                if (lock_q == LockLast) begin
                    state_d = ENTRY;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q + LockW'(1);
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    // State, counters and registered decodes of the next state.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= ENTRY;
            fail_q     <= '0;
            lock_q     <= '0;
            entry_en_q <= 1'b1;
            msg_q      <= 2'd0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
            entry_en_q <= (state_d == ENTRY);
            msg_q      <= msg_mode_of(state_d);
            lockout_q  <= (state_d == LOCKED);
        end
    end

`ifdef LOCK_ATTEMPT_SCROLL_EN
    localparam int unsigned ScrollW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [ScrollW-1:0] ScrollLast = ScrollW'(SCROLL_CYCLES - 1);

    logic [ScrollW-1:0] scroll_q, scroll_d;
    logic               tick_q, tick_d;

    // Scroll only while a message is shown; any state change restarts the count.
    always_comb begin
        scroll_d = '0;
        tick_d   = 1'b0;
        if ((state_q != ENTRY) && (state_d == state_q)) begin
            if (scroll_q == ScrollLast) begin
                tick_d = 1'b1;
            end else begin
                scroll_d = scroll_q + ScrollW'(1);
            end
        end
    end

    // Scroll counter and registered tick.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            scroll_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            scroll_q <= scroll_d;
            tick_q   <= tick_d;
        end
    end

    assign ctrl_io.scroll_tick = tick_q;
`else
    logic unused_scroll_cfg;
    assign unused_scroll_cfg   = ^SCROLL_CYCLES;
    assign ctrl_io.scroll_tick = 1'b0;
`endif

    assign ctrl_io.entry_en = entry_en_q;
    assign ctrl_io.msg_mode = msg_q;
    assign ctrl_io.fail_cnt = fail_q;
    assign ctrl_io.lockout  = lockout_q;

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Scoreboard bench for lock_attempt_ctrl (DEBOUNCE=4, SCROLL=8, LOCK=20, MAX_FAIL=3).
// Stimulus pushes the expected {entry_en, msg_mode, fail_cnt, lockout} tuple for each
// output change; the monitor pops and compares whenever the DUT outputs change.
module tb_lock_attempt_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    lock_attempt_ctrl_if #(.FAIL_W(2)) ctrl_if ();

    lock_attempt_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SCROLL_CYCLES  (8),
        .LOCK_CYCLES    (20),
        .MAX_FAIL       (3),
        .FAIL_W         (2)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .ctrl_io (ctrl_if)
    );

    int         checks = 0;
    int         failures = 0;
    logic [5:0] exp_q[$];
    int         tick_cyc[$];
    int         cyc = 0;
    int         last_change_cyc = 0;
    bit         mon_en = 1'b0;
    logic [5:0] prev;

    function automatic logic [5:0] tup(input bit en, input int msg, input int fc, input bit lk);
        return {en, 2'(msg), 2'(fc), lk};
    endfunction

    function automatic logic [5:0] cur_tup();
        return {ctrl_if.entry_en, ctrl_if.msg_mode, ctrl_if.fail_cnt, ctrl_if.lockout};
    endfunction

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Monitor: one comparison per observed output change, plus tick logging.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [5:0] cur;
            logic [5:0] e;
            cur = cur_tup();
            if (cur !== prev) begin
                last_change_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no_change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL output_change cyc=%0d got=%b required=%b", cyc, cur, e);
                    end
                end
                prev = cur;
            end
            if (ctrl_if.scroll_tick === 1'b1) tick_cyc.push_back(cyc);
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int hold);
        ctrl_if.key_enter = 1'b0;
        step(hold);
        ctrl_if.key_enter = 1'b1;
        step(3);
    endtask

    task automatic expect_out(input bit en, input int msg, input int fc, input bit lk);
        exp_q.push_back(tup(en, msg, fc, lk));
    endtask

    // PASS/FAIL/LOCKED dwell: ticks every 8 cycles, first 8 after entry (or none).
    task automatic check_ticks(input string name, input int start);
`ifdef LOCK_ATTEMPT_SCROLL_EN
        check({name, "_count_ge3"}, int'(tick_cyc.size() >= 3), 1);
        for (int i = 0; i < tick_cyc.size(); i++) begin
            check(name, tick_cyc[i], start + 8 * (i + 1));
        end
`else
        check({name, "_count"}, tick_cyc.size(), 0);
        check({name, "_start_seen"}, int'(start > 0), 1);
`endif
    endtask

    initial begin
        int pass_cyc;
        int lk_in;
        ctrl_if.key_enter = 1'b1;
        ctrl_if.match     = 1'b0;
        reset_n           = 1'b0;
        step(3);
        check("reset_outputs", int'(cur_tup()), int'(tup(1, 0, 0, 0)));
        check("reset_scroll_tick", int'(ctrl_if.scroll_tick), 0);
        prev   = tup(1, 0, 0, 0);
        mon_en = 1'b1;
        reset_n = 1'b1;
        step(2);

        // Long hold with match: exactly one pulse, then PASS dwell with ticks.
        ctrl_if.match = 1'b1;
        tick_cyc.delete();
        expect_out(0, 1, 0, 0);
        press(50);
        pass_cyc = last_change_cyc;
        step(20);
        check_ticks("pass_scroll", pass_cyc);
        expect_out(1, 0, 0, 0);
        press(6);
        tick_cyc.delete();
        step(30);
        check("entry_no_ticks", tick_cyc.size(), 0);

        // Three failures with returns to ENTRY in between, ending LOCKED.
        ctrl_if.match = 1'b0;
        expect_out(0, 2, 1, 0); press(6);
        expect_out(1, 0, 1, 0); press(6);
        expect_out(0, 2, 2, 0); press(6);
        expect_out(1, 0, 2, 0); press(6);
        expect_out(0, 3, 3, 1); press(6);
        lk_in = last_change_cyc;

        // ENTER with match while LOCKED is ignored; timed exit after 20 cycles.
        ctrl_if.match = 1'b1;
        expect_out(1, 0, 0, 0);
        press(6);
        step(15);
        check("lock_duration", last_change_cyc - lk_in, 20);

        // Two fails then a match clears the count; next fail is FAIL not LOCKED.
        ctrl_if.match = 1'b0;
        expect_out(0, 2, 1, 0); press(6);
        expect_out(1, 0, 1, 0); press(6);
        expect_out(0, 2, 2, 0); press(6);
        expect_out(1, 0, 2, 0); press(6);
        ctrl_if.match = 1'b1;
        expect_out(0, 1, 0, 0); press(6);
        expect_out(1, 0, 0, 0); press(6);
        ctrl_if.match = 1'b0;
        expect_out(0, 2, 1, 0); press(6);
        expect_out(1, 0, 1, 0); press(6);

        // 3-cycle glitch is below the debounce threshold.
        ctrl_if.key_enter = 1'b0;
        step(3);
        ctrl_if.key_enter = 1'b1;
        step(10);
        check("glitch_no_change", int'(cur_tup()), int'(tup(1, 0, 1, 0)));

        // Reset from FAIL aborts back to ENTRY with a cleared count.
        expect_out(0, 2, 2, 0); press(6);
        expect_out(1, 0, 0, 0);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(1);
        check("reset_from_fail", int'(cur_tup()), int'(tup(1, 0, 0, 0)));
        ctrl_if.match = 1'b1;
        expect_out(0, 1, 0, 0); press(6);
        step(5);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
